// File: rtl/lr_job_scheduler.sv
// Round-robin scheduler sharing one linear-regressor core among NREQ requesters.
// Optional watchdog abort when LR_SCHED_TIMEOUT_EN is defined.
module lr_job_scheduler #(
  parameter int NREQ        = 4,
  parameter int ERR_W       = 20,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         timeout,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    core_start,
  input  logic                    core_ready,
  input  logic [ERR_W-1:0]        core_err,
  output logic                    core_rst,
  output logic [ERR_W-1:0]        err_out,
  output logic                    err_valid,
  output logic [$clog2(NREQ)-1:0] err_id
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {S_IDLE, S_START, S_ACK, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_last;
  logic [IDW-1:0]    r_gnt;
  logic              r_busy;
  logic              r_start;
  logic [NREQ-1:0]   r_done;
  logic [ERR_W-1:0]  r_err;
  logic              r_err_valid;
  logic [IDW-1:0]    r_err_id;

  logic              w_any;
  logic [IDW-1:0]    w_pick;
  logic [IDW-1:0]    w_cand;

  // Search upward from last+1 with wrap; the just-served index is naturally last.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_cand = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = IDW'((int'(r_last) + i) % NREQ);
      if (!w_any && req[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

`ifdef LR_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0]   r_wdog;
  logic              r_core_rst;
  logic [NREQ-1:0]   r_timeout;
  logic              w_wd_hit;
  logic              w_leaving;

  assign w_wd_hit  = (r_wdog == WD_W'(TIMEOUT_CYC - 1));
  assign w_leaving = ((r_state == S_ACK) && !core_ready) || ((r_state == S_RUN) && core_ready);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= IDW'(NREQ - 1);
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= '0;
      r_err       <= '0;
      r_err_valid <= 1'b0;
      r_err_id    <= '0;
`ifdef LR_SCHED_TIMEOUT_EN
      r_wdog      <= '0;
      r_core_rst  <= 1'b0;
      r_timeout   <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
`ifdef LR_SCHED_TIMEOUT_EN
      r_core_rst <= 1'b0;
      r_timeout  <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_pick;
            r_busy  <= 1'b1;
            r_start <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_state <= S_ACK;
`ifdef LR_SCHED_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end
        // The ready-low edge is the first running cycle, so its sample is captured here.
        S_ACK: begin
          if (!core_ready) begin
            r_err       <= core_err;
            r_err_id    <= r_gnt;
            r_err_valid <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (core_ready) begin
            r_err_valid   <= 1'b0;
            r_done[r_gnt] <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_err       <= core_err;
            r_err_id    <= r_gnt;
            r_err_valid <= 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef LR_SCHED_TIMEOUT_EN
      // NOTE: these non-blocking writes come after the case, so on a watchdog hit
      // they take precedence over the normal ACK/RUN assignments made above.
      if ((r_state == S_ACK) || (r_state == S_RUN)) begin
        r_wdog <= r_wdog + 1'b1;
        if (w_wd_hit && !w_leaving) begin
          r_core_rst       <= 1'b1;
          r_timeout[r_gnt] <= 1'b1;
          r_done[r_gnt]    <= 1'b1;
          r_err_valid      <= 1'b0;
          r_state          <= S_DONE;
        end
      end
`endif
    end
  end

  assign done       = r_done;
  assign busy       = r_busy;
  assign gnt_id     = r_gnt;
  assign core_start = r_start;
  assign err_out    = r_err;
  assign err_valid  = r_err_valid;
  assign err_id     = r_err_id;

`ifdef LR_SCHED_TIMEOUT_EN
  assign timeout  = r_timeout;
  assign core_rst = r_core_rst;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC > 0);
  assign timeout  = '0;
  assign core_rst = 1'b0;
`endif

endmodule

// File: tb/tb_lr_job_scheduler.sv
// Directed bench for lr_job_scheduler: a behavioural core is driven from the main
// sequence and per-sample error values are checked through a scoreboard queue.
module tb_lr_job_scheduler;

  localparam int NREQ  = 4;
  localparam int ERR_W = 20;
  localparam int IDW   = 2;
  localparam int TMO   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   timeout;
  logic              busy;
  logic [IDW-1:0]    gnt_id;
  logic              core_start;
  logic              core_ready;
  logic [ERR_W-1:0]  core_err;
  logic              core_rst;
  logic [ERR_W-1:0]  err_out;
  logic              err_valid;
  logic [IDW-1:0]    err_id;

  lr_job_scheduler #(.NREQ(NREQ), .ERR_W(ERR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .timeout(timeout), .busy(busy),
    .gnt_id(gnt_id), .core_start(core_start), .core_ready(core_ready),
    .core_err(core_err), .core_rst(core_rst), .err_out(err_out),
    .err_valid(err_valid), .err_id(err_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [ERR_W-1:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   start_cnt = 0;
  int   ev_cnt    = 0;
  int   done_cnt[NREQ] = '{default: 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: counts pulses and pops the scoreboard on every valid sample.
  always @(negedge clk) begin
    if (core_start === 1'b1) start_cnt++;
    for (int b = 0; b < NREQ; b++) if (done[b] === 1'b1) done_cnt[b]++;
    if (err_valid === 1'b1) begin
      exp_t e;
      ev_cnt++;
      check("err_pending", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("err_out", 32'(err_out), 32'(e.val));
        check("err_id", 32'(err_id), 32'(e.id));
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
    check({tag, "_core_start"}, 32'(core_start), 32'd0);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    check({tag, "_err_out"}, 32'(err_out), 32'd0);
    check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
    check({tag, "_err_id"}, 32'(err_id), 32'd0);
  endtask

  task automatic wait_start(input int exp_id);
    int n;
    n = 0;
    while (core_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(core_start), 32'd1);
    check("gnt_id", 32'(gnt_id), 32'(exp_id));
    check("busy_at_start", 32'(busy), 32'd1);
  endtask

  task automatic push_sample(input int id);
    exp_t e;
    logic [31:0] v;
    v         = $urandom;
    core_err  = v[ERR_W-1:0];
    e.id      = IDW'(id);
    e.val     = v[ERR_W-1:0];
    q.push_back(e);
  endtask

  // One complete job: ready held high for pre cycles in ACK, low for low cycles.
  task automatic run_job(input int exp_id, input int pre, input int low,
                         input logic [NREQ-1:0] drop_mask, input logic [NREQ-1:0] rel_mask);
    int n;
    wait_start(exp_id);
    @(posedge clk); #1;
    for (int i = 0; i < pre; i++) begin
      @(posedge clk); #1;
      check("ack_hold_valid", 32'(err_valid), 32'd0);
      check("ack_hold_busy", 32'(busy), 32'd1);
    end
    for (int i = 0; i < low; i++) begin
      core_ready = 1'b0;
      push_sample(exp_id);
      if (i == low / 2) req = req & ~drop_mask;
      @(posedge clk); #1;
    end
    core_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (done === '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("done", 32'(done), 32'(1 << exp_id));
    check("done_timeout", 32'(timeout), 32'd0);
    check("done_core_rst", 32'(core_rst), 32'd0);
    check("done_valid", 32'(err_valid), 32'd0);
    req = req & ~rel_mask;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int s0, e0, d1, fired;
    rst = 1'b1; req = '0; core_ready = 1'b1; core_err = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Contention: 1011 held, order 0,1,3,0,1,3.
    req = 4'b1011;
    run_job(0, 2, 3, 4'b0000, 4'b0000);
    run_job(1, 1, 2, 4'b0000, 4'b0000);
    run_job(3, 2, 4, 4'b0000, 4'b0000);
    run_job(0, 1, 3, 4'b0000, 4'b0000);
    run_job(1, 2, 2, 4'b0000, 4'b0000);
    run_job(3, 1, 3, 4'b0000, 4'b1111);
    check("cont_done0", 32'(done_cnt[0]), 32'd2);
    check("cont_done1", 32'(done_cnt[1]), 32'd2);
    check("cont_done2", 32'(done_cnt[2]), 32'd0);
    check("cont_done3", 32'(done_cnt[3]), 32'd2);

    // Single job: one start, ten samples.
    s0 = start_cnt; e0 = ev_cnt;
    req = 4'b0001;
    run_job(0, 2, 10, 4'b0000, 4'b0001);
    repeat (5) @(negedge clk);
    check("single_starts", 32'(start_cnt - s0), 32'd1);
    check("single_samples", 32'(ev_cnt - e0), 32'd10);
    check("single_done0", 32'(done_cnt[0]), 32'd3);

    // Request dropped mid-run still completes, no regrant.
    req = 4'b0100;
    run_job(2, 1, 6, 4'b0100, 4'b0000);
    s0 = start_cnt;
    repeat (10) @(negedge clk);
    check("drop_no_regrant", 32'(start_cnt - s0), 32'd0);
    check("drop_idle", 32'(busy), 32'd0);
    check("drop_done2", 32'(done_cnt[2]), 32'd1);

    // Stale ready: 5 high cycles in ACK, then 4 low.
    e0 = ev_cnt;
    req = 4'b1000;
    run_job(3, 5, 4, 4'b0000, 4'b1000);
    check("stale_samples", 32'(ev_cnt - e0), 32'd4);

    // Reset mid-RUN: no done, then index 0 wins with all requesting.
    d1 = done_cnt[1];
    req = 4'b0010;
    wait_start(1);
    @(posedge clk); #1;
    core_ready = 1'b0;
    push_sample(1);
    @(posedge clk); #1;
    push_sample(1);
    @(posedge clk); #1;
    rst = 1'b1; req = '0;
    @(posedge clk); #1;
    rst = 1'b0; core_ready = 1'b1;
    @(negedge clk);
    check_reset("midrun_reset");
    repeat (4) @(negedge clk);
    check("midrun_no_done", 32'(done_cnt[1] - d1), 32'd0);
    check("midrun_queue", 32'(q.size()), 32'd0);
    req = 4'b1111;
    run_job(0, 1, 3, 4'b0000, 4'b1111);

`ifdef LR_SCHED_TIMEOUT_EN
    // Watchdog: ready stuck low, abort 16 cycles after entering ACK.
    req = 4'b0100;
    wait_start(2);
    @(posedge clk); #1;
    core_ready = 1'b0;
    fired = 0;
    for (int k = 1; k <= 30 && fired == 0; k++) begin
      if (k < TMO) push_sample(2);
      else core_err = ERR_W'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (core_rst === 1'b1) fired = k;
    end
    check("tmo_cycle", 32'(fired), 32'(TMO));
    check("tmo_done", 32'(done), 32'b0100);
    check("tmo_flag", 32'(timeout), 32'b0100);
    check("tmo_valid", 32'(err_valid), 32'd0);
    req = '0; core_ready = 1'b1;
    @(negedge clk);
    check("tmo_core_rst_pulse", 32'(core_rst), 32'd0);
    check("tmo_flag_pulse", 32'(timeout), 32'd0);
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_queue", 32'(q.size()), 32'd0);
    req = 4'b0001;
    run_job(0, 2, 3, 4'b0000, 4'b0001);
`else
    fired = 0;
    check("no_tmo_core_rst", 32'(core_rst), 32'(fired));
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
